// File: rtl/mem_rr_multiport.sv
// Single-port RAM shared by NUM_RD read channels and one write channel.
// A round-robin arbiter grants at most one req/ack access per cycle.
module mem_rr_multiport #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int MEM_DEPTH  = 16,
    parameter int NUM_RD     = 2
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           iWrReq,
    input  logic [ADDR_WIDTH-1:0]          iWrAddr,
    input  logic [DATA_WIDTH-1:0]          iWrData,
    output logic                           oWrAck,
    input  logic [NUM_RD-1:0]              iRdReq,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   iRdAddr,
    output logic [NUM_RD-1:0]              oRdAck,
    output logic [NUM_RD-1:0]              oRdValid,
    output logic [NUM_RD*DATA_WIDTH-1:0]   oRdData,
    output logic                           oAddrErr
);

    localparam int N     = NUM_RD + 1;
    localparam int PTR_W = $clog2(N);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0]        mem_q [MEM_DEPTH];
    logic [N-1:0]                 req;
    logic [PTR_W-1:0]             ptr_q, ptr_d, gnt_idx;
    logic                         gnt_vld;
    logic [ADDR_WIDTH-1:0]        gnt_addr;
    logic                         addr_ok;
    logic [NUM_RD-1:0]            rd_ack;
    logic                         wr_ack;
    logic [NUM_RD-1:0]            rd_vld_q, rd_vld_d;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    assign req = {iWrReq, iRdReq};

    // Scan upward from ptr_q with wrap at N; the first active requestor wins.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (sum >= (PTR_W + 1)'(N)) sum = sum - (PTR_W + 1)'(N);
            idx = sum[PTR_W-1:0];
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        gnt_addr = iWrAddr;
        for (int k = 0; k < NUM_RD; k++) begin
            if (gnt_idx == PTR_W'(k)) gnt_addr = iRdAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
        addr_ok = ({1'b0, gnt_addr} < DEPTH_L);
        wr_ack  = gnt_vld && !Reset && (gnt_idx == PTR_W'(NUM_RD));
        for (int k = 0; k < NUM_RD; k++) begin
            rd_ack[k] = gnt_vld && !Reset && (gnt_idx == PTR_W'(k));
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) ptr_d = (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        rd_vld_d  = rd_ack;
        rd_data_d = rd_data_q;
        for (int k = 0; k < NUM_RD; k++) begin
            if (rd_ack[k]) begin
                rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = addr_ok ? mem_q[gnt_addr] : '0;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ptr_q     <= '0;
            rd_vld_q  <= '0;
            rd_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
        end
    end

    // RAM contents deliberately survive reset; out-of-range writes are dropped.
    always_ff @(posedge Clock) begin
        if (wr_ack && addr_ok) mem_q[iWrAddr] <= iWrData;
    end

    assign oWrAck   = wr_ack;
    assign oRdAck   = rd_ack;
    assign oRdValid = rd_vld_q;
    assign oRdData  = rd_data_q;
    assign oAddrErr = gnt_vld && !Reset && !addr_ok;

endmodule

// File: tb/tb_mem_rr_multiport.sv
// Directed bench for mem_rr_multiport (NUM_RD=2, MEM_DEPTH=12).
module tb_mem_rr_multiport;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iWrReq;
    logic [3:0]  iWrAddr;
    logic [7:0]  iWrData;
    logic        oWrAck;
    logic [1:0]  iRdReq;
    logic [7:0]  iRdAddr;
    logic [1:0]  oRdAck;
    logic [1:0]  oRdValid;
    logic [15:0] oRdData;
    logic        oAddrErr;

    int checks = 0;
    int errors = 0;

    mem_rr_multiport #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .MEM_DEPTH(12), .NUM_RD(2)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .iWrReq(iWrReq), .iWrAddr(iWrAddr), .iWrData(iWrData), .oWrAck(oWrAck),
        .iRdReq(iRdReq), .iRdAddr(iRdAddr), .oRdAck(oRdAck),
        .oRdValid(oRdValid), .oRdData(oRdData), .oAddrErr(oAddrErr)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check one cycle's acks/valid/err at the falling edge, then advance past the next rising edge.
    task automatic cyc(input string tag, input logic [1:0] eack, input logic ewack,
                       input logic [1:0] evld, input logic eerr);
        @(negedge Clock);
        chk({tag, ".rdack"}, 32'(oRdAck), 32'(eack));
        chk({tag, ".wrack"}, 32'(oWrAck), 32'(ewack));
        chk({tag, ".vld"}, 32'(oRdValid), 32'(evld));
        chk({tag, ".err"}, 32'(oAddrErr), 32'(eerr));
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; iWrReq = 1'b0; iWrAddr = '0; iWrData = '0;
        iRdReq = '0; iRdAddr = '0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst.wrack", 32'(oWrAck), 0);
        chk("rst.rdack", 32'(oRdAck), 0);
        chk("rst.vld", 32'(oRdValid), 0);
        chk("rst.err", 32'(oAddrErr), 0);
        chk("rst.data", 32'(oRdData), 0);
        Reset = 1'b0;

        // Reset lands between a read ack and its data cycle.
        iRdReq = 2'b01; iRdAddr = 8'h00;
        @(negedge Clock);
        chk("t1.ack", 32'(oRdAck), 32'h1);
        @(posedge Clock);
        #1;
        iRdReq = '0; Reset = 1'b1;
        #1;
        chk("t1.vld", 32'(oRdValid), 0);
        chk("t1.data", 32'(oRdData), 0);
        @(negedge Clock);
        chk("t1.vld2", 32'(oRdValid), 0);
        chk("t1.rdack", 32'(oRdAck), 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        // All requestors held from reset: ch0, ch1, wr, ch0, ...
        iRdReq = 2'b11; iRdAddr = {4'd3, 4'd3};
        iWrReq = 1'b1; iWrAddr = 4'd3; iWrData = 8'hA5;
        cyc("t3.c0", 2'b01, 1'b0, 2'b00, 1'b0);
        cyc("t3.c1", 2'b10, 1'b0, 2'b01, 1'b0);
        cyc("t3.c2", 2'b00, 1'b1, 2'b10, 1'b0);
        cyc("t3.c3", 2'b01, 1'b0, 2'b00, 1'b0);
        chk("t3.d0", 32'(oRdData[7:0]), 32'hA5);
        cyc("t3.c4", 2'b10, 1'b0, 2'b01, 1'b0);
        chk("t3.d1", 32'(oRdData[15:8]), 32'hA5);
        cyc("t3.c5", 2'b00, 1'b1, 2'b10, 1'b0);
        cyc("t3.c6", 2'b01, 1'b0, 2'b00, 1'b0);

        // Single write then read of address 3 (ptr is now 1).
        iRdReq = '0; iWrReq = 1'b1; iWrAddr = 4'd3; iWrData = 8'hA5;
        cyc("t2.wr", 2'b00, 1'b1, 2'b01, 1'b0);
        iWrReq = 1'b0; iRdReq = 2'b01; iRdAddr = {4'd0, 4'd3};
        cyc("t2.rd", 2'b01, 1'b0, 2'b00, 1'b0);
        iRdReq = '0;
        chk("t2.data", 32'(oRdData[7:0]), 32'hA5);
        cyc("t2.done", 2'b00, 1'b0, 2'b01, 1'b0);

        // Write @5 then read ch1 @5 the very next cycle (ptr is now 1).
        iWrReq = 1'b1; iWrAddr = 4'd5; iWrData = 8'h3C;
        cyc("t4.wr", 2'b00, 1'b1, 2'b00, 1'b0);
        iWrReq = 1'b0; iRdReq = 2'b10; iRdAddr = {4'd5, 4'd0};
        cyc("t4.rd", 2'b10, 1'b0, 2'b00, 1'b0);
        iRdReq = '0;
        chk("t4.data", 32'(oRdData[15:8]), 32'h3C);
        cyc("t4.done", 2'b00, 1'b0, 2'b10, 1'b0);

        // Out-of-range write and read against MEM_DEPTH=12 (ptr is now 2).
        iWrReq = 1'b1; iWrAddr = 4'd11; iWrData = 8'h77;
        cyc("t5.wr11", 2'b00, 1'b1, 2'b00, 1'b0);
        iWrAddr = 4'd15; iWrData = 8'hEE;
        cyc("t5.wr15", 2'b00, 1'b1, 2'b00, 1'b1);
        iWrReq = 1'b0; iRdReq = 2'b01; iRdAddr = {4'd0, 4'd15};
        cyc("t5.rd15", 2'b01, 1'b0, 2'b00, 1'b1);
        iRdReq = 2'b10; iRdAddr = {4'd11, 4'd0};
        chk("t5.d15", 32'(oRdData[7:0]), 0);
        chk("t5.keep1", 32'(oRdData[15:8]), 32'h3C);
        cyc("t5.rd11", 2'b10, 1'b0, 2'b01, 1'b0);
        iRdReq = '0;
        chk("t5.d11", 32'(oRdData[15:8]), 32'h77);
        cyc("t5.done", 2'b00, 1'b0, 2'b10, 1'b0);

        // Channel isolation (ptr is now 2).
        iWrReq = 1'b1; iWrAddr = 4'd0; iWrData = 8'h11;
        cyc("t6.wr0", 2'b00, 1'b1, 2'b00, 1'b0);
        iWrAddr = 4'd1; iWrData = 8'h22;
        cyc("t6.wr1", 2'b00, 1'b1, 2'b00, 1'b0);
        iWrReq = 1'b0; iRdReq = 2'b01; iRdAddr = {4'd0, 4'd0};
        cyc("t6.rd0", 2'b01, 1'b0, 2'b00, 1'b0);
        chk("t6.d0", 32'(oRdData[7:0]), 32'h11);
        iRdReq = 2'b10; iRdAddr = {4'd1, 4'd0};
        cyc("t6.rd1", 2'b10, 1'b0, 2'b01, 1'b0);
        iRdReq = '0;
        chk("t6.d0hold", 32'(oRdData[7:0]), 32'h11);
        chk("t6.d1", 32'(oRdData[15:8]), 32'h22);
        cyc("t6.done", 2'b00, 1'b0, 2'b10, 1'b0);
        chk("t6.d0final", 32'(oRdData[7:0]), 32'h11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
